// File: rtl/fetch_ctrl_pkg.sv
// Shared constants for the fetch controller: reset PC, RISC-V opcodes,
// FSM state encodings and a word-alignment helper.
package fetch_ctrl_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [6:0]  OPC_JAL    = 7'b110_1111;
  localparam logic [6:0]  OPC_BRANCH = 7'b110_0011;
  localparam logic [31:0] PC_STEP    = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_e;

  // Clear the two byte-offset bits so every address stays word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_ctrl_immgen.sv
// Immediate extraction for the static predictor: J-type and B-type
// immediates, sign extended. The opcode field is not needed here.
module fetch_ctrl_immgen (
  input  logic [31:7] inst,
  output logic [31:0] j_imm,
  output logic [31:0] b_imm
);

  // Pure bit shuffling of the instruction word.
  always_comb begin
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: IDLE/FETCH/DROP FSM issuing one word-aligned
// read per cycle, holding the address under stall or back-pressure and
// steering to execute-stage redirects. A redirect that lands while a request
// is outstanding moves to DROP so the stale response is discarded.
// Optional build macro STATIC_BTFN_EN adds backward-taken/forward-not-taken
// static prediction (JAL always taken, backward branches taken).
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IMem_stall_i,
  input  logic [31:0] Inst_i,
  output logic        IMem_ren_o,
  output logic [31:0] IMem_addr_o,
  output logic [31:0] Inst_o,
  output logic [31:0] PC_o,
  output logic        Inst_valid_o,
  input  logic        Ready_i,
  input  logic        Redirect_i,
  input  logic [31:0] Redirect_pc_i,
  output logic        Pred_taken_o
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] addr_q;

  logic [31:0] redirect_target;
  logic [31:0] add_operand;
  logic [31:0] next_pc;
  logic        accept;

  // Request outputs and the decode handshake are decoded from the state.
  always_comb begin
    redirect_target = word_align(Redirect_pc_i);
    IMem_ren_o      = (state_q != ST_IDLE);
    IMem_addr_o     = addr_q;
    Inst_o          = Inst_i;
    PC_o            = addr_q;
    Inst_valid_o    = (state_q == ST_FETCH) & ~IMem_stall_i & ~Redirect_i;
    accept          = Inst_valid_o & Ready_i;
  end

`ifdef STATIC_BTFN_EN
  logic [31:0] j_imm;
  logic [31:0] b_imm;
  logic        is_jal;
  logic        is_back_branch;

  fetch_ctrl_immgen u_immgen (
    .inst  (Inst_i[31:7]),
    .j_imm (j_imm),
    .b_imm (b_imm)
  );

  // JAL is always taken; a conditional branch is taken only when it jumps back.
  always_comb begin
    is_jal         = (Inst_i[6:0] == OPC_JAL);
    is_back_branch = (Inst_i[6:0] == OPC_BRANCH) & b_imm[31];
    if (is_jal) begin
      add_operand = j_imm;
    end else if (is_back_branch) begin
      add_operand = b_imm;
    end else begin
      add_operand = PC_STEP;
    end
    Pred_taken_o = Inst_valid_o & (is_jal | is_back_branch);
  end
`else
  // Without prediction the next PC is always sequential.
  always_comb begin
    add_operand  = PC_STEP;
    Pred_taken_o = 1'b0;
  end
`endif

  // Single target adder; wraps modulo 2^32.
  always_comb begin
    next_pc = word_align(addr_q + add_operand);
  end

  // Fetch FSM: redirect has priority, otherwise advance on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_FETCH;
          if (Redirect_i) begin
            pc_q   <= redirect_target;
            addr_q <= redirect_target;
          end else begin
            addr_q <= pc_q;
          end
        end
        ST_FETCH: begin
          if (Redirect_i) begin
            pc_q <= redirect_target;
            if (IMem_stall_i) begin
              // Keep the outstanding address until memory answers.
              state_q <= ST_DROP;
            end else begin
              addr_q <= redirect_target;
            end
          end else if (accept) begin
            pc_q   <= next_pc;
            addr_q <= next_pc;
          end
        end
        ST_DROP: begin
          if (Redirect_i) begin
            pc_q <= redirect_target;
          end else if (!IMem_stall_i) begin
            state_q <= ST_FETCH;
            addr_q  <= pc_q;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          pc_q    <= RESET_PC;
          addr_q  <= RESET_PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl. Inputs change on the falling edge, outputs
// are sampled 1ns later. Expectations for prediction depend on STATIC_BTFN_EN.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        IMem_stall_i;
  logic [31:0] Inst_i;
  logic        IMem_ren_o;
  logic [31:0] IMem_addr_o;
  logic [31:0] Inst_o;
  logic [31:0] PC_o;
  logic        Inst_valid_o;
  logic        Ready_i;
  logic        Redirect_i;
  logic [31:0] Redirect_pc_i;
  logic        Pred_taken_o;

  int tests_run;
  int tests_failed;

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] BEQ_NEG = 32'hFE00_0CE3; // beq x0,x0,-8
  localparam logic [31:0] BEQ_POS = 32'h0000_0463; // beq x0,x0,+8
  localparam logic [31:0] JAL_800 = 32'h0010_006F; // jal x0,+0x800

`ifdef STATIC_BTFN_EN
  localparam logic        EXP_PRED     = 1'b1;
  localparam logic [31:0] EXP_BR_NEXT  = 32'h0000_0038;
  localparam logic [31:0] EXP_JAL_NEXT = 32'h0000_0900;
`else
  localparam logic        EXP_PRED     = 1'b0;
  localparam logic [31:0] EXP_BR_NEXT  = 32'h0000_0044;
  localparam logic [31:0] EXP_JAL_NEXT = 32'h0000_0104;
`endif

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .IMem_stall_i  (IMem_stall_i),
    .Inst_i        (Inst_i),
    .IMem_ren_o    (IMem_ren_o),
    .IMem_addr_o   (IMem_addr_o),
    .Inst_o        (Inst_o),
    .PC_o          (PC_o),
    .Inst_valid_o  (Inst_valid_o),
    .Ready_i       (Ready_i),
    .Redirect_i    (Redirect_i),
    .Redirect_pc_i (Redirect_pc_i),
    .Pred_taken_o  (Pred_taken_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
    $display("[TB] t=%0t %s observed=%h expected=%h", $time, tag, got, exp);
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    rst_n         = 1'b0;
    IMem_stall_i  = 1'b0;
    Ready_i       = 1'b1;
    Redirect_i    = 1'b0;
    Redirect_pc_i = 32'h0;
    Inst_i        = NOP;

    #2;
    chk("rst_ren",   {31'd0, IMem_ren_o},   32'd0);
    chk("rst_addr",  IMem_addr_o,           32'h0);
    chk("rst_valid", {31'd0, Inst_valid_o}, 32'd0);
    chk("rst_pred",  {31'd0, Pred_taken_o}, 32'd0);

    // Release: one IDLE cycle, then sequential fetch from 0.
    @(negedge clk); rst_n = 1'b1; #1;
    chk("idle_ren", {31'd0, IMem_ren_o}, 32'd0);
    @(negedge clk); #1;
    chk("f0_ren",   {31'd0, IMem_ren_o},   32'd1);
    chk("f0_addr",  IMem_addr_o,           32'h0);
    chk("f0_valid", {31'd0, Inst_valid_o}, 32'd1);
    chk("f0_pc",    PC_o,                  32'h0);
    chk("f0_inst",  Inst_o,                NOP);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); #1;
      chk("seq_addr", IMem_addr_o, 32'(i * 4));
    end

    // Back-pressure at 0x10 for three cycles.
    Ready_i = 1'b0;
    chk("hold_valid", {31'd0, Inst_valid_o}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("hold_addr",  IMem_addr_o,           32'h10);
      chk("hold_valid", {31'd0, Inst_valid_o}, 32'd1);
    end
    Ready_i = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      @(negedge clk); #1;
      chk("seq2_addr", IMem_addr_o, 32'(i * 4));
    end

    // Redirect to 0x203 while 0x20 is stalled: DROP, then 0x200.
    IMem_stall_i = 1'b1; #1;
    chk("stall_valid", {31'd0, Inst_valid_o}, 32'd0);
    Redirect_i = 1'b1; Redirect_pc_i = 32'h203; #1;
    chk("redir_stall_valid", {31'd0, Inst_valid_o}, 32'd0);
    @(negedge clk); Redirect_i = 1'b0; #1;
    chk("drop_addr",  IMem_addr_o,           32'h20);
    chk("drop_ren",   {31'd0, IMem_ren_o},   32'd1);
    chk("drop_valid", {31'd0, Inst_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("drop2_addr", IMem_addr_o, 32'h20);
    IMem_stall_i = 1'b0; #1;
    chk("drop_resp_valid", {31'd0, Inst_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("tgt_addr",  IMem_addr_o,           32'h200);
    chk("tgt_valid", {31'd0, Inst_valid_o}, 32'd1);

    // Unstalled redirect to 0x40, backward branch there.
    Redirect_i = 1'b1; Redirect_pc_i = 32'h40; #1;
    chk("redir_valid", {31'd0, Inst_valid_o}, 32'd0);
    @(negedge clk); Redirect_i = 1'b0; Inst_i = BEQ_NEG; #1;
    chk("brn_addr", IMem_addr_o,           32'h40);
    chk("brn_pred", {31'd0, Pred_taken_o}, {31'd0, EXP_PRED});
    @(negedge clk); Inst_i = NOP; #1;
    chk("brn_next", IMem_addr_o, EXP_BR_NEXT);

    // Forward branch at 0x40: never predicted.
    Redirect_i = 1'b1; Redirect_pc_i = 32'h40;
    @(negedge clk); Redirect_i = 1'b0; Inst_i = BEQ_POS; #1;
    chk("brp_addr", IMem_addr_o,           32'h40);
    chk("brp_pred", {31'd0, Pred_taken_o}, 32'd0);
    @(negedge clk); Inst_i = NOP; #1;
    chk("brp_next", IMem_addr_o, 32'h44);

    // JAL +0x800 at 0x100.
    Redirect_i = 1'b1; Redirect_pc_i = 32'h100;
    @(negedge clk); Redirect_i = 1'b0; Inst_i = JAL_800; #1;
    chk("jal_addr", IMem_addr_o,           32'h100);
    chk("jal_pred", {31'd0, Pred_taken_o}, {31'd0, EXP_PRED});
    @(negedge clk); Inst_i = NOP; #1;
    chk("jal_next", IMem_addr_o, EXP_JAL_NEXT);

    // Wrap at the top of the address space.
    Redirect_i = 1'b1; Redirect_pc_i = 32'hFFFF_FFFC;
    @(negedge clk); Redirect_i = 1'b0; #1;
    chk("wrap_addr", IMem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    chk("wrap_next", IMem_addr_o, 32'h0);
    @(negedge clk); IMem_stall_i = 1'b1; #1;
    chk("pre_rst_addr", IMem_addr_o, 32'h4);

    // Asynchronous reset in the middle of a stalled request.
    @(negedge clk); #1;
    chk("stall_hold_ren", {31'd0, IMem_ren_o}, 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst_ren",   {31'd0, IMem_ren_o},   32'd0);
    chk("midrst_addr",  IMem_addr_o,           32'h0);
    chk("midrst_valid", {31'd0, Inst_valid_o}, 32'd0);
    IMem_stall_i = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_idle_valid", {31'd0, Inst_valid_o}, 32'd0);
    @(negedge clk); #1;
    chk("rel_addr",  IMem_addr_o,           32'h0);
    chk("rel_valid", {31'd0, Inst_valid_o}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: IMem_stall_i  in  1  instruction memory busy; response valid in the cycle it is low.
REQ-004 SHALL have: Inst_i  in  32  instruction word from memory, valid when request active and IMem_stall_i=0.
REQ-005 SHALL have: IMem_ren_o  out  1  read request; IMem_addr_o  out  32  request address, word aligned.
REQ-006 SHALL have: Inst_o  out  32  fetched instruction; PC_o  out  32  its address; Inst_valid_o  out  1.
REQ-007 SHALL have: Ready_i  in  1  decode accepts Inst_o when Inst_valid_o=1 and Ready_i=1.
REQ-008 SHALL have: Redirect_i  in  1  and Redirect_pc_i  in  32  execute-stage target (mispredict/JALR).
REQ-009 SHALL have: Pred_taken_o  out  1  fetched instruction was predicted taken.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH, DROP.
REQ-011 IDLE: ren=0; next cycle unconditionally FETCH with IMem_addr_o=pc_q.
REQ-012 FETCH: ren=1; IMem_addr_o held stable while IMem_stall_i=1.
REQ-013 Inst_valid_o = (state==FETCH) & ~IMem_stall_i & ~Redirect_i; Inst_o=Inst_i, PC_o=IMem_addr_o combinationally.
REQ-014 If valid and Ready_i=0, SHALL re-issue same address next cycle; pc_q unchanged.
REQ-015 On accept, pc_q and IMem_addr_o SHALL load next-PC; zero added bubble, one fetch per cycle at no stall.
REQ-016 Next-PC default = PC+4, 32-bit modulo (0xFFFFFFFC -> 0x00000000).
REQ-017 Redirect_i SHALL have highest priority: target = Redirect_pc_i with bits[1:0] forced 0.
REQ-018 Redirect while FETCH and IMem_stall_i=0: load target, stay FETCH, current response discarded.
REQ-019 Redirect while FETCH and IMem_stall_i=1: pc_q <= target, go DROP; outstanding address held.
REQ-020 DROP: ren=1, address held, Inst_valid_o=0; on IMem_stall_i=0 go FETCH with IMem_addr_o=pc_q.
REQ-021 Redirect while DROP: pc_q <= newest target, remain DROP.
REQ-022 Redirect in IDLE: pc_q <= target, then FETCH as normal.

Reset
REQ-023 rst_n=0 SHALL force state=IDLE, pc_q=IMem_addr_o=RESET_PC (32'h0), ren=0, Inst_valid_o=0, Pred_taken_o=0, regardless of clock.
REQ-024 Reset mid-fetch SHALL abandon the outstanding request; no response accepted after release.

Configuration
REQ-025 Macro STATIC_BTFN_EN SHALL enable static prediction on accepted instruction.
REQ-026 Enabled: opcode JAL -> next-PC = PC+J-imm, Pred_taken_o=1; BRANCH with negative B-imm -> PC+B-imm, Pred_taken_o=1; else PC+4.
REQ-027 Disabled: next-PC always PC+4 (or redirect); Pred_taken_o tied 0; no immediate hardware instantiated.

Structure
REQ-028 Opcode constants, RESET_PC, state encodings SHALL live in shared Const.v.
REQ-029 Immediate extraction SHALL use one ImmGen sub-module instance on Inst_i, only under STATIC_BTFN_EN.
REQ-030 Target adder SHALL be single 32-bit adder muxing imm vs 4.

Verification
REQ-031 Reset release, stall=0, Ready=1 -> IDLE one cycle, then addresses 0x0,0x4,0x8 on consecutive cycles.
REQ-032 Ready_i=0 for 3 cycles at PC 0x10 -> address 0x10 held, Inst_valid_o high, next accept goes to 0x14.
REQ-033 Redirect_i with Redirect_pc_i=0x203 while stall=1 at 0x20 -> DROP, addr 0x20 held until stall low, then 0x200; no valid for 0x20.
REQ-034 STATIC_BTFN_EN, BRANCH at 0x40 with imm -8 accepted -> next address 0x38, Pred_taken_o=1; positive imm -> 0x44, Pred_taken_o=0.
REQ-035 JAL at 0x100 imm +0x800 with macro -> 0x900; without macro -> 0x104.
REQ-036 PC 0xFFFFFFFC accepted -> next address 0x00000000; rst_n low mid-stall -> ren=0 immediately.
